// File: rtl/reg_file_16x16.sv
// Register file with 16 registers of 16 bits each. It has two combinational read ports and
// one synchronous write port. R0 is hardwired to zero. Writes can bypass to reads in the same cycle.
module reg_file_16x16 #(
   parameter int DATA_W    = 16,
   parameter int ADDR_W    = 4,
   parameter int NUM_REGS  = 16,
   parameter int BYPASS_EN = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] SrcReg1,
   input  logic [ADDR_W-1:0] SrcReg2,
   input  logic [ADDR_W-1:0] DstReg,
   input  logic              WriteReg,
   input  logic [DATA_W-1:0] DstData,
   output logic [DATA_W-1:0] SrcData1,
   output logic [DATA_W-1:0] SrcData2,
   output logic              Err
);

   localparam int NUM_RD = 2;

   logic [NUM_REGS-1:0][DATA_W-1:0] regs;
   logic                            wr_hit;
   logic [NUM_RD-1:0][ADDR_W-1:0]   src;
   logic [NUM_RD-1:0][DATA_W-1:0]   rdata;

   // The R0 slot is never written, so it stays at its reset value of zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         regs <= '0;
         Err  <= 1'b0;
      end else if (WriteReg) begin
         if (DstReg != '0)
            regs[DstReg] <= DstData;
         else
            Err <= 1'b1;
      end
   end

   assign wr_hit = !rst && WriteReg && (DstReg != '0);
   assign src    = {SrcReg2, SrcReg1};

   for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
      logic [DATA_W-1:0] q;
      always_comb begin
         q = regs[src[p]];
         if (BYPASS_EN != 0 && wr_hit && src[p] == DstReg)
            q = DstData;
         // Reset and address 0 both take priority over bypass.
         if (rst || src[p] == '0)
            q = '0;
      end
      assign rdata[p] = q;
   end

   assign SrcData1 = rdata[0];
   assign SrcData2 = rdata[1];

endmodule
